// File: rtl/mips_pkg.sv
// Shared MIPS definitions: controller state encoding, ALU operation codes,
// opcode/funct constants and the I-type ALU operation helper.
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        REXEC  = 4'd6,
        RWB    = 4'd7,
        BREX   = 4'd8,
        IEXEC  = 4'd9,
        IWB    = 4'd10,
        JEX    = 4'd11
    } state_t;

    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_ADD = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1010;
    localparam logic [3:0] ALU_SRL = 4'b1011;
    localparam logic [3:0] ALU_LUI = 4'b1100;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SLT = 6'h2A;

    function automatic logic [3:0] imm_alu_oper(input logic [5:0] op);
        case (op)
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            OP_LUI:  return ALU_LUI;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mips_alu_dec.sv
// R-type funct to ALU operation decoder; valid=0 flags an unsupported funct.
module mips_alu_dec
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_oper,
    output logic       valid
);

    always_comb begin
        valid = 1'b1;
        case (funct)
            FN_ADD:  alu_oper = ALU_ADD;
            FN_SUB:  alu_oper = ALU_SUB;
            FN_AND:  alu_oper = ALU_AND;
            FN_OR:   alu_oper = ALU_OR;
            FN_XOR:  alu_oper = ALU_XOR;
            FN_SLT:  alu_oper = ALU_SLT;
            FN_SLL:  alu_oper = ALU_SLL;
            FN_SRL:  alu_oper = ALU_SRL;
            default: begin
                alu_oper = ALU_NOP;
                valid    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM with memory wait timeout.
// Define MIPS_MC_CTRL_BNE_EN to add bne (opcode 0x05) support.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] alu_oper,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       mem_err,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    localparam int              CW       = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(MEM_WAIT_MAX - 1);

    state_t        state, state_nx;
    logic [CW-1:0] wait_cnt;
    logic          waiting, timeout;
    logic [3:0]    fn_oper;
    logic          fn_valid;

    mips_alu_dec u_alu_dec (
        .funct    (funct),
        .alu_oper (fn_oper),
        .valid    (fn_valid)
    );

    // A ready in the last allowed wait cycle still counts as a completed access.
    assign waiting   = state inside {FETCH, MEMRD, MEMWR};
    assign timeout   = rst_n && waiting && !mem_ready && (wait_cnt == CNT_LAST);
    assign state_dbg = state;

    always_comb begin
        state_nx = state;
        case (state)
            FETCH:  if (mem_ready) state_nx = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:                    state_nx = MEMADR;
                    OP_RTYPE:                        state_nx = REXEC;
                    OP_BEQ:                          state_nx = BREX;
`ifdef MIPS_MC_CTRL_BNE_EN
                    OP_BNE:                          state_nx = BREX;
`endif
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_nx = IEXEC;
                    OP_J:                            state_nx = JEX;
                    default:                         state_nx = FETCH;
                endcase
            end
            MEMADR: state_nx = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready) state_nx = MEMWB;
                    else if (timeout) state_nx = FETCH;
            MEMWR:  if (mem_ready || timeout) state_nx = FETCH;
            REXEC:  state_nx = fn_valid ? RWB : FETCH;
            IEXEC:  state_nx = IWB;
            default: state_nx = FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state || timeout || !waiting)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would infer a latch.
    always_comb begin
        alu_oper   = ALU_NOP;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pc_src     = 2'b00;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        mem_err    = 1'b0;
        illegal_op = 1'b0;
        if (timeout) begin
            mem_err = 1'b1;
        end else begin
            case (state)
                FETCH: begin
                    mem_read = 1'b1;
                    alusrcb  = 2'b01;
                    alu_oper = ALU_ADD;
                    ir_write = mem_ready;
                    pc_en    = mem_ready;
                end
                DECODE: begin
                    alusrcb    = 2'b11;
                    alu_oper   = ALU_ADD;
                    illegal_op = (state_nx == FETCH);
                end
                MEMADR: begin
                    alusrca  = 1'b1;
                    alusrcb  = 2'b10;
                    alu_oper = ALU_ADD;
                end
                MEMRD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                end
                MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                MEMWR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                end
                REXEC: begin
                    alu_oper   = fn_oper;
                    illegal_op = !fn_valid;
                end
                RWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                BREX: begin
                    alu_oper = ALU_SUB;
                    alusrca  = 1'b1;
                    pc_src   = 2'b01;
`ifdef MIPS_MC_CTRL_BNE_EN
                    pc_en    = (opcode == OP_BNE) ? ~zero : zero;
`else
                    pc_en    = zero;
`endif
                end
                IEXEC: begin
                    alusrca  = 1'b1;
                    alusrcb  = 2'b10;
                    alu_oper = imm_alu_oper(opcode);
                end
                IWB:     reg_write = 1'b1;
                JEX: begin
                    pc_src = 2'b10;
                    pc_en  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: per-cycle expected control words are
// queued with the stimulus and compared against the DUT each cycle.
module tb_mips_mc_ctrl;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic [3:0] alu_oper, state_dbg;
    logic       alusrca;
    logic [1:0] alusrcb, pc_src;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_write;
    logic       reg_dst, mem_to_reg, mem_err, illegal_op;

    mips_mc_ctrl #(.MEM_WAIT_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .alu_oper(alu_oper), .alusrca(alusrca),
        .alusrcb(alusrcb), .pc_src(pc_src), .pc_en(pc_en), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .mem_err(mem_err), .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Strobe field order: pc_en iord mem_read mem_write ir_write reg_write reg_dst mem_to_reg mem_err illegal_op
    localparam logic [9:0] S_PCEN = 10'b1000000000;
    localparam logic [9:0] S_IORD = 10'b0100000000;
    localparam logic [9:0] S_MRD  = 10'b0010000000;
    localparam logic [9:0] S_MWR  = 10'b0001000000;
    localparam logic [9:0] S_IRW  = 10'b0000100000;
    localparam logic [9:0] S_RWR  = 10'b0000010000;
    localparam logic [9:0] S_RDST = 10'b0000001000;
    localparam logic [9:0] S_M2R  = 10'b0000000100;
    localparam logic [9:0] S_MERR = 10'b0000000010;
    localparam logic [9:0] S_ILL  = 10'b0000000001;

    typedef struct {
        string       tag;
        logic        rdy;
        logic [22:0] exp;
    } item_t;

    item_t       sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [22:0] obs;

    assign obs = {state_dbg, alu_oper, alusrca, alusrcb, pc_src, pc_en, iord, mem_read,
                  mem_write, ir_write, reg_write, reg_dst, mem_to_reg, mem_err, illegal_op};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [22:0] ev(input logic [3:0] st, input logic [3:0] aop, input logic asa,
                                       input logic [1:0] asb, input logic [1:0] psrc, input logic [9:0] stb);
        return {st, aop, asa, asb, psrc, stb};
    endfunction

    task automatic push(input string tag, input logic rdy, input logic [22:0] exp);
        item_t it;
        it.tag = tag; it.rdy = rdy; it.exp = exp;
        sb.push_back(it);
    endtask

    task automatic p_fetch(input string n, input logic rdy);
        push({n, ".FETCH"}, rdy, ev(4'(FETCH), 4'b0101, 1'b0, 2'b01, 2'b00,
                                    S_MRD | (rdy ? (S_PCEN | S_IRW) : 10'b0)));
    endtask

    task automatic p_decode(input string n, input logic ill);
        push({n, ".DECODE"}, 1'b1, ev(4'(DECODE), 4'b0101, 1'b0, 2'b11, 2'b00, ill ? S_ILL : 10'b0));
    endtask

    task automatic p_memadr(input string n);
        push({n, ".MEMADR"}, 1'b1, ev(4'(MEMADR), 4'b0101, 1'b1, 2'b10, 2'b00, 10'b0));
    endtask

    // Each cycle: apply that cycle's mem_ready, compare, then move to the next cycle.
    task automatic run_sb();
        item_t it;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            mem_ready = it.rdy;
            #1;
            check(it.tag, 32'(obs), 32'(it.exp));
            @(negedge clk);
        end
    endtask

    task automatic set_ir(input logic [5:0] op, input logic [5:0] fn, input logic z);
        opcode = op; funct = fn; zero = z;
    endtask

    logic [5:0] r_fn  [4] = '{6'h2A, 6'h20, 6'h22, 6'h02};
    logic [3:0] r_aop [4] = '{4'b1000, 4'b0101, 4'b0110, 4'b1011};
    logic [5:0] i_op  [4] = '{6'h08, 6'h0C, 6'h0D, 6'h0F};
    logic [3:0] i_aop [4] = '{4'b0101, 4'b0001, 4'b0011, 4'b1100};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n = 1'b0; mem_ready = 1'b0;
        set_ir(6'h00, 6'h00, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check("rst.state",   32'(state_dbg),  32'(FETCH));
        check("rst.mem_err", 32'(mem_err),    32'd0);
        check("rst.ill",     32'(illegal_op), 32'd0);
        check("rst.mem_read", 32'(mem_read),  32'd1);
        check("rst.ir_write", 32'(ir_write),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // lw, with two FETCH wait cycles first
        set_ir(OP_LW, 6'h00, 1'b0);
        p_fetch("lw", 1'b0); p_fetch("lw", 1'b0); p_fetch("lw", 1'b1);
        p_decode("lw", 1'b0); p_memadr("lw");
        push("lw.MEMRD", 1'b1, ev(4'(MEMRD), 4'b0000, 1'b0, 2'b00, 2'b00, S_IORD | S_MRD));
        push("lw.MEMWB", 1'b1, ev(4'(MEMWB), 4'b0000, 1'b0, 2'b00, 2'b00, S_RWR | S_M2R));
        run_sb();

        // sw
        set_ir(OP_SW, 6'h00, 1'b0);
        p_fetch("sw", 1'b1); p_decode("sw", 1'b0); p_memadr("sw");
        push("sw.MEMWR", 1'b1, ev(4'(MEMWR), 4'b0000, 1'b0, 2'b00, 2'b00, S_IORD | S_MWR));
        run_sb();

        // R-type legal functs
        for (int i = 0; i < 4; i++) begin
            set_ir(OP_RTYPE, r_fn[i], 1'b0);
            p_fetch($sformatf("r%0h", r_fn[i]), 1'b1);
            p_decode($sformatf("r%0h", r_fn[i]), 1'b0);
            push($sformatf("r%0h.REXEC", r_fn[i]), 1'b1, ev(4'(REXEC), r_aop[i], 1'b0, 2'b00, 2'b00, 10'b0));
            push($sformatf("r%0h.RWB", r_fn[i]), 1'b1, ev(4'(RWB), 4'b0000, 1'b0, 2'b00, 2'b00, S_RWR | S_RDST));
            run_sb();
        end

        // R-type illegal funct: single-cycle illegal_op then FETCH
        set_ir(OP_RTYPE, 6'h3F, 1'b0);
        p_fetch("rbad", 1'b1); p_decode("rbad", 1'b0);
        push("rbad.REXEC", 1'b1, ev(4'(REXEC), 4'b0000, 1'b0, 2'b00, 2'b00, S_ILL));
        p_fetch("rbad.after", 1'b0);
        run_sb();

        // I-type
        for (int i = 0; i < 4; i++) begin
            set_ir(i_op[i], 6'h00, 1'b0);
            p_fetch($sformatf("i%0h", i_op[i]), 1'b1);
            p_decode($sformatf("i%0h", i_op[i]), 1'b0);
            push($sformatf("i%0h.IEXEC", i_op[i]), 1'b1, ev(4'(IEXEC), i_aop[i], 1'b1, 2'b10, 2'b00, 10'b0));
            push($sformatf("i%0h.IWB", i_op[i]), 1'b1, ev(4'(IWB), 4'b0000, 1'b0, 2'b00, 2'b00, S_RWR));
            run_sb();
        end

        // beq taken / not taken
        for (int z = 1; z >= 0; z--) begin
            set_ir(OP_BEQ, 6'h00, 1'(z));
            p_fetch($sformatf("beq_z%0d", z), 1'b1);
            p_decode($sformatf("beq_z%0d", z), 1'b0);
            push($sformatf("beq_z%0d.BREX", z), 1'b1,
                 ev(4'(BREX), 4'b0110, 1'b1, 2'b00, 2'b01, (z == 1) ? S_PCEN : 10'b0));
            run_sb();
        end

        // j
        set_ir(OP_J, 6'h00, 1'b0);
        p_fetch("j", 1'b1); p_decode("j", 1'b0);
        push("j.JEX", 1'b1, ev(4'(JEX), 4'b0000, 1'b0, 2'b00, 2'b10, S_PCEN));
        run_sb();

        // undefined opcode
        set_ir(6'h3F, 6'h00, 1'b0);
        p_fetch("op3f", 1'b1); p_decode("op3f", 1'b1); p_fetch("op3f.after", 1'b0);
        run_sb();

        // bne: depends on build option
        for (int z = 0; z < 2; z++) begin
            set_ir(OP_BNE, 6'h00, 1'(z));
            p_fetch($sformatf("bne_z%0d", z), 1'b1);
`ifdef MIPS_MC_CTRL_BNE_EN
            p_decode($sformatf("bne_z%0d", z), 1'b0);
            push($sformatf("bne_z%0d.BREX", z), 1'b1,
                 ev(4'(BREX), 4'b0110, 1'b1, 2'b00, 2'b01, (z == 0) ? S_PCEN : 10'b0));
`else
            p_decode($sformatf("bne_z%0d", z), 1'b1);
`endif
            run_sb();
        end

        // lw memory timeout: 14 quiet wait cycles, error on the 15th, then FETCH
        set_ir(OP_LW, 6'h00, 1'b0);
        p_fetch("lwto", 1'b1); p_decode("lwto", 1'b0); p_memadr("lwto");
        for (int i = 1; i <= 14; i++)
            push($sformatf("lwto.MEMRD%0d", i), 1'b0, ev(4'(MEMRD), 4'b0000, 1'b0, 2'b00, 2'b00, S_IORD | S_MRD));
        push("lwto.MEMRD15", 1'b0, ev(4'(MEMRD), 4'b0000, 1'b0, 2'b00, 2'b00, S_MERR));
        p_fetch("lwto.after", 1'b0);
        run_sb();

        // lw where ready arrives on the 15th wait cycle: completes without error
        set_ir(OP_LW, 6'h00, 1'b0);
        p_fetch("lwlate", 1'b1); p_decode("lwlate", 1'b0); p_memadr("lwlate");
        for (int i = 1; i <= 14; i++)
            push($sformatf("lwlate.MEMRD%0d", i), 1'b0, ev(4'(MEMRD), 4'b0000, 1'b0, 2'b00, 2'b00, S_IORD | S_MRD));
        push("lwlate.MEMRD15", 1'b1, ev(4'(MEMRD), 4'b0000, 1'b0, 2'b00, 2'b00, S_IORD | S_MRD));
        push("lwlate.MEMWB", 1'b1, ev(4'(MEMWB), 4'b0000, 1'b0, 2'b00, 2'b00, S_RWR | S_M2R));
        run_sb();

        // asynchronous reset in the middle of a stalled sw
        set_ir(OP_SW, 6'h00, 1'b0);
        p_fetch("swrst", 1'b1); p_decode("swrst", 1'b0); p_memadr("swrst");
        push("swrst.MEMWR", 1'b0, ev(4'(MEMWR), 4'b0000, 1'b0, 2'b00, 2'b00, S_IORD | S_MWR));
        run_sb();
        #1;
        check("swrst.pre_mem_write", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("swrst.mem_write", 32'(mem_write), 32'd0);
        check("swrst.state",     32'(state_dbg), 32'(FETCH));
        check("swrst.mem_err",   32'(mem_err),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // normal instruction after the aborted one
        set_ir(OP_J, 6'h00, 1'b0);
        p_fetch("jpost", 1'b1); p_decode("jpost", 1'b0);
        push("jpost.JEX", 1'b1, ev(4'(JEX), 4'b0000, 1'b0, 2'b00, 2'b10, S_PCEN));
        run_sb();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15, meaning the maximum number of cycles a memory state waits for mem_ready.
REQ-002 SHALL have port clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port opcode  input  6  IR[31:26].
REQ-005 SHALL have port funct  input  6  IR[5:0].
REQ-006 SHALL have port zero  input  1  ALU zero flag.
REQ-007 SHALL have port mem_ready  input  1  memory access completes this cycle.
REQ-008 SHALL have port alu_oper  output  4  ALU operation code.
REQ-009 SHALL have ports alusrca (output, 1), alusrcb (output, 2), pc_src (output, 2) as datapath mux selects.
REQ-010 SHALL have 1-bit outputs: pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg.
REQ-011 SHALL have outputs mem_err (1), illegal_op (1) and state_dbg (4, current state encoding).

Function
REQ-012 SHALL implement the states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB, BREX, IEXEC, IWB and JEX.
REQ-013 SHALL compute all outputs combinationally from the state, except that alu_oper in REXEC is also decoded from funct and pc_en also depends on zero.
REQ-014 SHALL use these alu_oper encodings: AND=0001, XOR=0010, OR=0011, ADD=0101, SUB=0110, SLT=1000, SLL=1010, SRL=1011, LUI=1100.
REQ-015 SHALL, in FETCH, drive mem_read=1, iord=0, alusrca=0, alusrcb=01, alu_oper=ADD and ir_write=mem_ready, and drive pc_write=mem_ready through pc_en with pc_src=00; it SHALL stay in FETCH until mem_ready=1, then go to DECODE.
REQ-016 SHALL, in DECODE, drive alusrca=0, alusrcb=11 and alu_oper=ADD (branch target), then branch on opcode: 0x23/0x2B->MEMADR, 0x00->REXEC, 0x04->BREX, 0x08/0x0C/0x0D/0x0F->IEXEC, 0x02->JEX, any other opcode->FETCH with illegal_op=1 for exactly one cycle.
REQ-017 SHALL, in MEMADR, drive alusrca=1, alusrcb=10 and alu_oper=ADD, then go to MEMRD for lw or MEMWR for sw.
REQ-018 SHALL, in MEMRD, drive iord=1 and mem_read=1, and move to MEMWB on mem_ready; MEMWB SHALL drive reg_write=1, mem_to_reg=1 and reg_dst=0, then go to FETCH.
REQ-019 SHALL, in MEMWR, drive iord=1 and mem_write=1, and move to FETCH on mem_ready.
REQ-020 SHALL, in REXEC, decode funct as 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x2A SLT, 0x00 SLL, 0x02 SRL; an unlisted funct SHALL pulse illegal_op and go to FETCH; otherwise it SHALL go to RWB, which drives reg_write=1, reg_dst=1 and mem_to_reg=0.
REQ-021 SHALL, in IEXEC, drive alusrca=1 and alusrcb=10, with alu_oper ADD for 0x08, AND for 0x0C, OR for 0x0D and LUI for 0x0F; IWB SHALL then drive reg_write=1 and reg_dst=0.
REQ-022 SHALL, in BREX, drive alu_oper=SUB, alusrca=1, alusrcb=00, pc_src=01 and pc_en=zero, then go to FETCH.
REQ-023 SHALL, in JEX, drive pc_src=10 and pc_en=1, then go to FETCH.
REQ-024 SHALL, in every state that waits on mem_ready, count wait cycles; on reaching MEMWAIT_MAX without mem_ready it SHALL pulse mem_err for one cycle, deassert all strobes and go to FETCH; the counter SHALL clear on every state change.
REQ-025 SHALL, if mem_ready and the timeout coincide, treat the cycle as a completed access with no mem_err.
REQ-026 SHALL drive every strobe not listed for a state to 0 and every mux select not listed for a state to 0.
REQ-027 SHALL take 5 cycles for lw, 4 for sw, R-type and I-type, and 3 for beq and j, when mem_ready is held 1.

Reset
REQ-028 SHALL, while rst_n=0, force state=FETCH, clear the wait counter and hold mem_err=0 and illegal_op=0; the other outputs SHALL follow the FETCH decode.
REQ-029 SHALL abort any in-flight instruction on mid-operation reset with no further strobes, restarting in FETCH.

Configuration
REQ-030 SHALL, with MIPS_MC_CTRL_BNE_EN defined, decode opcode 0x05 to BREX with pc_en=~zero; without it, 0x05 SHALL be illegal.

Structure
REQ-031 SHALL take the state enumeration, alu_oper codes, opcode and funct constants from shared package mips_pkg, also used by the ALU and datapath.
REQ-032 SHALL place the funct-to-alu_oper decode in sub-module mips_alu_dec.

Verification
REQ-033 SHALL verify: lw (0x23) with mem_ready=1 throughout -> FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 and mem_to_reg=1 only in cycle 5.
REQ-034 SHALL verify: R-type funct=0x2A -> alu_oper=1000 in REXEC and reg_dst=1 in RWB; funct=0x2A with 0x3F -> illegal_op single pulse.
REQ-035 SHALL verify: beq with zero=1 gives pc_en=1 and pc_src=01 in BREX; with zero=0, pc_en=0.
REQ-036 SHALL verify: mem_ready held 0 in MEMRD with MEM_WAIT_MAX=15 -> mem_err pulses on the 15th wait cycle and the next state is FETCH.
REQ-037 SHALL verify: rst_n driven low mid-MEMWR -> mem_write drops asynchronously and state_dbg=FETCH.
REQ-038 SHALL verify: opcode 0x05 -> BREX with pc_en=~zero when MIPS_MC_CTRL_BNE_EN is defined, and illegal_op when it is not.
